// File: rtl/mips_pkg.sv
// Shared constants and helpers for the pipelined select mux.
//   DATA_W_DEFAULT : default channel width in bits
//   clog2()        : ceiling log2, used to size the channel select
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // Returns the number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer: a main register that drives the outputs and a
// skid register that absorbs one beat when the consumer stalls. in_ready is
// a flop (the inverse of the skid valid), so it never depends on out_ready
// in the same cycle.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop both entries at the next edge
//   in_data/in_valid    : upstream word and its valid
//   in_ready            : buffer can accept this cycle
//   out_data/out_valid  : main entry contents and its valid
//   out_ready           : downstream accepts this cycle
module skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         main_v;
  logic         skid_v;
  logic         rdy_q;
  logic         in_xfer;
  logic         main_free;

  assign in_xfer   = in_valid & rdy_q;
  // Main can take a new word when empty or draining this edge.
  assign main_free = ~main_v | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_d <= '0;
      skid_d <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else if (flush) begin
      // Any input offered alongside flush is dropped; a simultaneous output
      // handshake has already completed from the consumer's point of view.
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (main_free) begin
      if (skid_v) begin
        // rdy_q is low whenever skid is full, so no input competes here.
        main_d <= skid_d;
        main_v <= 1'b1;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end else begin
        main_v <= in_xfer;
        if (in_xfer) begin
          main_d <= in_data;
        end
        rdy_q <= 1'b1;
      end
    end else if (in_xfer) begin
      skid_d <= in_data;
      skid_v <= 1'b1;
      rdy_q  <= 1'b0;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = main_d;
  assign out_valid = main_v;

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N-way channel select with a valid/ready interface.
// The channel chosen by sel is captured into a two-entry skid buffer; an
// out-of-range sel yields a zero word flagged by out_err.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_data             : N_IN packed channels, channel k at [k*DATA_W +: DATA_W]
//   sel                 : channel index, sampled with in_data
//   in_valid/in_ready   : input handshake
//   flush               : discard all held entries
//   out_data/out_err    : selected word and out-of-range flag
//   out_valid/out_ready : output handshake
module pipe_sel_mux
  import mips_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int N_IN   = 4,
  localparam int SEL_W  = clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_err;
  logic [DATA_W:0]   buf_out;

  // Default is the out-of-range result; a matching channel overrides it.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_data[k*DATA_W +: DATA_W];
        sel_err  = 1'b0;
      end
    end
  end

  skid_buf #(
    .W (DATA_W + 1)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   ({sel_err, sel_data}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_err  = buf_out[DATA_W];
  assign out_data = buf_out[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_sel_mux.sv
module tb_pipe_sel_mux;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // N_IN = 4 instance
  logic [4*DW-1:0] in_data;
  logic [1:0]      sel;
  logic            in_valid, in_ready, flush;
  logic [DW-1:0]   out_data;
  logic            out_err, out_valid, out_ready;

  // N_IN = 3 instance (out-of-range select)
  logic [3*DW-1:0] in_data3;
  logic [1:0]      sel3;
  logic            in_valid3, in_ready3, flush3;
  logic [DW-1:0]   out_data3;
  logic            out_err3, out_valid3, out_ready3;

  pipe_sel_mux #(.DATA_W(DW), .N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready));

  pipe_sel_mux #(.DATA_W(DW), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
    .out_ready(out_ready3));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick channel s from an array view of the bus.
  function automatic exp_t model(input logic [4*DW-1:0] bus, input logic [1:0] s);
    logic [DW-1:0] ch [4];
    exp_t r;
    for (int k = 0; k < 4; k++) ch[k] = bus[k*DW +: DW];
    if (int'(s) < 4) begin
      r.d = ch[int'(s)];
      r.e = 1'b0;
    end else begin
      r.d = '0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  // One clock edge has been seen since reset release.
  logic since_rst;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) since_rst <= 1'b0;
    else        since_rst <= 1'b1;
  end

  // Observer: queue holds exactly the words currently buffered in the DUT.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_e;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q.delete();
    check("obs_in_ready", in_ready, rst_n && since_rst && (q.size() < 2));
    check("obs_out_valid", out_valid, rst_n && (q.size() > 0));
    if (rst_n && prev_hold) begin
      check("obs_hold_data", out_data, prev_d);
      check("obs_hold_err", out_err, prev_e);
    end
    prev_hold = rst_n && out_valid && !out_ready && !flush;
    prev_d = out_data;
    prev_e = out_err;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got %0h with nothing expected", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_err !== e.e) begin
            errors++;
            $display("FAIL sb_data: got %0h/%0b expected %0h/%0b", out_data, out_err, e.d, e.e);
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_data, sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] a_w, b_w, c_w;
  logic [1:0] sl [3];
  logic [DW-1:0] ed;
  logic          ee;
  logic          drained;

  initial begin
    rst_n = 1'b0; in_valid = 0; out_ready = 0; flush = 0; sel = 0; in_data = '0;
    in_valid3 = 0; out_ready3 = 1; flush3 = 0; sel3 = 0; in_data3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_before_edge", in_ready, 0);
    tick();
    check("rel_in_ready_after_edge", in_ready, 1);

    // Streaming
    out_ready = 1;
    for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = 32'h1000 + k;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k > 0) begin
        check("stream_valid", out_valid, 1);
        check("stream_data", out_data, 32'h1000 + k - 1);
      end
      if (k < 4) begin sel = 2'(k); in_valid = 1; end
      else in_valid = 0;
    end
    tick();
    check("stream_idle", out_valid, 0);

    // Backpressure
    a_w = 32'hA0A0_0001; b_w = 32'hB0B0_0002;
    in_data[1*DW +: DW] = a_w; sel = 1; in_valid = 1; out_ready = 1;
    tick();
    check("bp_a_main", out_data, a_w);
    out_ready = 0; in_data[2*DW +: DW] = b_w; sel = 2; in_valid = 1;
    tick();
    check("bp_skid_in_ready", in_ready, 0);
    check("bp_a_hold", out_data, a_w);
    in_valid = 0; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    check("bp_a_still", out_data, a_w);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1;
    tick();
    check("bp_b_main", out_data, b_w);
    check("bp_in_ready_back", in_ready, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Flush with both entries full
    out_ready = 0; in_data[0 +: DW] = 32'hD1; sel = 0; in_valid = 1;
    tick();
    in_data[1*DW +: DW] = 32'hD2; sel = 1;
    tick();
    check("fl_full_in_ready", in_ready, 0);
    c_w = 32'hC0FFEE; in_data[3*DW +: DW] = c_w; sel = 3; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    out_ready = 1;
    tick();
    check("fl_no_word", out_valid, 0);
    // Flush while in_ready=1: offered word must be discarded
    out_ready = 0; in_data[0 +: DW] = 32'hE1; sel = 0; in_valid = 1;
    tick();
    in_data[2*DW +: DW] = 32'hC2; sel = 2; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    check("fl2_out_valid", out_valid, 0);
    check("fl2_in_ready", in_ready, 1);
    out_ready = 1;
    tick();
    check("fl2_no_word", out_valid, 0);

    // Out-of-range select on N_IN=3
    for (int k = 0; k < 3; k++) in_data3[k*DW +: DW] = 32'h3000 + k;
    sl[0] = 2'd0; sl[1] = 2'd3; sl[2] = 2'd1;
    for (int k = 0; k <= 3; k++) begin
      tick();
      if (k > 0) begin
        ed = (int'(sl[k-1]) < 3) ? 32'h3000 + sl[k-1] : 32'h0;
        ee = (int'(sl[k-1]) >= 3);
        check("oor_valid", out_valid3, 1);
        check("oor_data", out_data3, ed);
        check("oor_err", out_err3, ee);
      end
      if (k < 3) begin sel3 = sl[k]; in_valid3 = 1; end
      else in_valid3 = 0;
    end

    // Reset mid-stream
    out_ready = 0; sel = 0; in_valid = 1;
    tick();
    tick();
    in_valid = 0;
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("mid_rel_in_ready_0", in_ready, 0);
    tick();
    check("mid_rel_in_ready_1", in_ready, 1);
    check("mid_rel_out_valid", out_valid, 0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
    end
    tick();
    in_valid = 0; flush = 0; out_ready = 1;
    drained = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !out_valid) drained = 1;
    end
    check("drain_done", drained, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
PIPE_SEL_MUX -- requirements
Module: pipe_sel_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of each data channel in bits.
REQ-002 The block SHALL have parameter N_IN, default 4, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have derived parameter SEL_W, default clog2(N_IN), meaning the select width; it is not overridable.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_data, input, N_IN*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel index, sampled with in_data.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data/sel.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all held entries.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the selected word.
REQ-012 The block SHALL have port out_err, output, 1 bit: out_data came from an out-of-range sel.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data/out_err are valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 The block SHALL hold two entries: a main register driving the outputs and a skid register; each entry holds {data, err, valid}.
REQ-017 The captured data SHALL be in_data channel sel when sel<N_IN; otherwise data=0 and err=1.
REQ-018 in_ready SHALL be a registered signal equal to NOT skid.valid; it SHALL NOT depend combinationally on out_ready.
REQ-019 Latency SHALL be 1 cycle: an input accepted at edge t with main empty, or main draining at t, SHALL appear on outputs after edge t.
REQ-020 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-021 When main is full, out_ready=0, and an input transfer occurs, the entry SHALL go to skid and in_ready SHALL drop after that edge.
REQ-022 When main drains and skid is full, skid SHALL move to main in the same edge and skid SHALL empty; in_ready SHALL rise after that edge.
REQ-023 Order SHALL be preserved; no entry SHALL be lost or duplicated absent flush.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_err SHALL remain stable.
REQ-025 flush=1 SHALL clear main.valid and skid.valid at the next edge; an input offered in the same cycle SHALL be discarded; a simultaneous output transfer SHALL still count as completed.
REQ-026 After a flush edge, in_ready SHALL be 1.

Reset
REQ-027 While rst_n=0, out_valid=0, out_err=0, out_data=0, in_ready=0, and both entries invalid, asynchronously.
REQ-028 in_ready SHALL become 1 at the first rising edge after rst_n deasserts; reset mid-transfer SHALL discard all entries.

Structure
REQ-029 The shared package mips_pkg SHALL hold the default DATA_W constant and the clog2 function; no other constants.
REQ-030 The two-entry buffer SHALL be a sub-module skid_buf (parameter W = DATA_W+1); selection logic stays in pipe_sel_mux.

Verification
REQ-031 Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=0 at once; in_ready=1 one edge after release.
REQ-032 Streaming: N_IN=4, channel k = 0x1000+k, sel 0,1,2,3 with out_ready=1 -> 0x1000..0x1003 on consecutive cycles, 1-cycle latency.
REQ-033 Backpressure: out_ready=0 after first beat, send A,B -> A held stable, B in skid, in_ready=0; out_ready=1 -> A then B, in_ready back to 1.
REQ-034 Out-of-range: N_IN=3, sel=3 -> out_data=0, out_err=1 for that beat only.
REQ-035 Flush: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word never appears.
REQ-036 Random: random in_valid/out_ready over 10000 cycles -> scoreboard order and content match, no loss or duplicates.
